seven_seg_capture: RTL

//  Receive end of the multiplexed 7-segment bus driven by seven_seg. Snoops AN/CATH, tracks the scan phase,

---
 rtl/seven_seg_pkg.sv | 35 +++
 rtl/seven_seg_cath_decode.sv | 28 ++
 rtl/seven_seg_capture.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
//  Shared definitions for the multiplexed 7-segment bus: geometry of the scan
//  frame, the 16-entry cathode pattern table (same encoding as the seven_seg
//  driver, bit0=a .. bit6=g, active-low), FSM state and anode classification
//  types, and the slot-advance helper.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

   localparam int AN_COUNT   = 8;
   localparam int CATH_COUNT = 7;
   localparam int DIGIT_SIZE = 4;
   localparam int SLOT_W     = $clog2(AN_COUNT);
   localparam int NUM_W      = AN_COUNT * DIGIT_SIZE;

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(AN_COUNT - 1);

   // Index = hex value; entry = cathode pattern {g,f,e,d,c,b,a}, 0 = segment lit.
   localparam logic [CATH_COUNT-1:0] CATH_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef enum logic {SYNC, TRACK} state_t;

   typedef enum logic [1:0] {AN_BLANK, AN_ACTIVE, AN_MULTI} an_class_t;

   // Slot following s in scan order, wrapping after the last slot.
   function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
      return (s == LAST_SLOT) ? '0 : s + 1'b1;
   endfunction

endpackage

// File: rtl/seven_seg_cath_decode.sv
// -----------------------------------------------------------------------------
// seven_seg_cath_decode
//  Combinational reverse lookup of a cathode pattern to its hex nibble.
//  Ports:
//   cath    in   CATH_COUNT   cathode pattern, active-low segments
//   legal   out  1            1 = pattern is one of the 16 hex glyphs
//   nibble  out  DIGIT_SIZE   decoded value (0 when not legal)
// -----------------------------------------------------------------------------
module seven_seg_cath_decode
   import seven_seg_pkg::*;
(
   input  logic [CATH_COUNT-1:0] cath,
   output logic                  legal,
   output logic [DIGIT_SIZE-1:0] nibble
);

   always_comb begin
      legal  = 1'b0;
      nibble = '0;
      for (int i = 0; i < 16; i++) begin
         if (cath == CATH_TABLE[i]) begin
            legal  = 1'b1;
            nibble = DIGIT_SIZE'(i);
         end
      end
   end

endmodule

// File: rtl/seven_seg_capture.sv
// -----------------------------------------------------------------------------
// seven_seg_capture
//  Receive side of the multiplexed 7-segment bus. Snoops AN/CATH, locks onto
//  the scan phase, decodes each slot back to a nibble and publishes the whole
//  NUMBER word plus blanked-digit mask once per clean scan frame.
//  Ports:
//   clk          in   1        system clock
//   RESET_N      in   1        asynchronous active-low reset
//   CE           in   1        slot strobe, one slot per CE=1 cycle
//   AN           in   AN_COUNT anode bus, active-low one-hot, all-ones = blank
//   CATH         in   7        cathode bus, active-low segments
//   NUMBER_OUT   out  32       last clean frame, digit i at [4i+3:4i]
//   DIGIT_MASK   out  8        1 = slot was blank in last clean frame
//   FRAME_VALID  out  1        pulse when NUMBER_OUT/DIGIT_MASK update
//   FRAME_ERR    out  1        pulse when a frame is discarded
//   LOCKED       out  1        scan phase known
// -----------------------------------------------------------------------------
module seven_seg_capture
   import seven_seg_pkg::*;
(
   input  logic                  clk,
   input  logic                  RESET_N,
   input  logic                  CE,
   input  logic [AN_COUNT-1:0]   AN,
   input  logic [CATH_COUNT-1:0] CATH,
   output logic [NUM_W-1:0]      NUMBER_OUT,
   output logic [AN_COUNT-1:0]   DIGIT_MASK,
   output logic                  FRAME_VALID,
   output logic                  FRAME_ERR,
   output logic                  LOCKED
);

   logic [AN_COUNT-1:0]   an_p1;
   logic [CATH_COUNT-1:0] cath_p1;
   logic                  vld_p1;

   logic                  legal;
   logic [DIGIT_SIZE-1:0] nibble;
   logic [SLOT_W:0]       zero_cnt;
   logic [SLOT_W-1:0]     act_idx;
   an_class_t             an_cls;

   state_t                state;
   logic [SLOT_W-1:0]     slot;
   logic                  frame_ok;
   logic                  partial;
   logic [NUM_W-1:0]      shadow_num_p2;
   logic [AN_COUNT-1:0]   shadow_mask_p2;

   logic                  start;
   logic                  hit;
   logic                  slip;
   logic                  clean;
   logic                  ok_nxt;
   logic                  frame_end;
   logic [SLOT_W-1:0]     slot_nxt;
   logic [NUM_W-1:0]      sh_num_nxt;
   logic [AN_COUNT-1:0]   sh_mask_nxt;
   int                    base;

   // ---- stage 1: register the bus and the slot strobe ----
   always_ff @(posedge clk) begin
      an_p1   <= AN;
      cath_p1 <= CATH;
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) vld_p1 <= 1'b0;
      else          vld_p1 <= CE;
   end

   // ---- stage 2: classify, decode, track phase, accumulate ----
   seven_seg_cath_decode u_decode (
      .cath   (cath_p1),
      .legal  (legal),
      .nibble (nibble)
   );

   always_comb begin
      zero_cnt = '0;
      act_idx  = '0;
      for (int k = 0; k < AN_COUNT; k++) begin
         if (!an_p1[k]) begin
            zero_cnt = zero_cnt + 1'b1;
            act_idx  = SLOT_W'(k);
         end
      end
      if (zero_cnt == '0)                          an_cls = AN_BLANK;
      else if (zero_cnt == {{SLOT_W{1'b0}}, 1'b1}) an_cls = AN_ACTIVE;
      else                                         an_cls = AN_MULTI;
   end

   // Slot 0 opens a fresh frame: the running ok flag and the shadow are
   // reseeded before this slot's own contribution is merged in.
   always_comb begin
      start       = (slot == '0);
      hit         = (an_cls == AN_ACTIVE) && (act_idx == slot);
      slip        = (an_cls == AN_ACTIVE) && (act_idx != slot);
      clean       = (an_cls == AN_BLANK) || (hit && legal);
      ok_nxt      = (start || frame_ok) && clean;
      sh_num_nxt  = start ? '0 : shadow_num_p2;
      sh_mask_nxt = start ? '1 : shadow_mask_p2;
      base        = int'(slot) * DIGIT_SIZE;
      if (an_cls == AN_BLANK) begin
         sh_num_nxt[base +: DIGIT_SIZE] = '0;
         sh_mask_nxt[slot]              = 1'b1;
      end else if (hit && legal) begin
         sh_num_nxt[base +: DIGIT_SIZE] = nibble;
         sh_mask_nxt[slot]              = 1'b0;
      end
      // A slip resyncs to the observed slot; that slot decides frame end.
      slot_nxt  = slip ? next_slot(act_idx) : next_slot(slot);
      frame_end = slip ? (act_idx == LAST_SLOT) : (slot == LAST_SLOT);
   end

   always_ff @(posedge clk) begin
      if (vld_p1 && state == TRACK) begin
         shadow_num_p2  <= sh_num_nxt;
         shadow_mask_p2 <= sh_mask_nxt;
      end
   end

   // partial marks the frame entered mid-way at lock; its end is not an error.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= SYNC;
         slot        <= '0;
         frame_ok    <= 1'b0;
         partial     <= 1'b0;
         NUMBER_OUT  <= '0;
         DIGIT_MASK  <= '1;
         FRAME_VALID <= 1'b0;
         FRAME_ERR   <= 1'b0;
      end else begin
         FRAME_VALID <= 1'b0;
         FRAME_ERR   <= 1'b0;
         if (vld_p1) begin
            case (state)
               SYNC: begin
                  if (an_cls == AN_ACTIVE) begin
                     slot     <= next_slot(act_idx);
                     frame_ok <= 1'b0;
                     partial  <= 1'b1;
                     state    <= TRACK;
                  end
               end
               TRACK: begin
                  slot     <= slot_nxt;
                  frame_ok <= ok_nxt;
                  if (start && !slip) partial <= 1'b0;
                  if (frame_end) begin
                     partial <= 1'b0;
                     if (ok_nxt) begin
                        NUMBER_OUT  <= sh_num_nxt;
                        DIGIT_MASK  <= sh_mask_nxt;
                        FRAME_VALID <= 1'b1;
                     end else if (!partial) begin
                        FRAME_ERR <= 1'b1;
                     end
                  end
               end
               default: state <= SYNC;
            endcase
         end
      end
   end

   assign LOCKED = (state == TRACK);

endmodule
